// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board serial link (transmitter and receiver).
package link_pkg;

    localparam int LINK_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        READ,
        GAP
    } link_state_t;

endpackage

// File: rtl/link_clk_gen.sv
// Link clock generator: divides clk down to ic_clk and flags the edge on which it toggles.
module link_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic en,
    input  logic clr,
    output logic ic_clk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    // Ticks describe the toggle that the coming edge will perform.
    assign terminal  = en && (div_cnt == DIV_LAST);
    assign rise_tick = terminal && !ic_clk;
    assign fall_tick = terminal && ic_clk;

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            ic_clk  <= 1'b0;
        end else if (en) begin
            if (terminal) begin
                div_cnt <= '0;
                ic_clk  <= ~ic_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/p2s_link_tx.sv
// Parallel-to-serial link transmitter: one-byte holding buffer, MSB-first shifter on a
// generated link clock, then a frame-complete read strobe and an inter-frame gap.
module p2s_link_tx
    import link_pkg::*;
#(
    parameter int DATA_W     = LINK_DATA_W,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] P_data_in,
    input  logic              load,
    output logic              ready,
    output logic              S_data_out,
    output logic              ic_clk_ctrl,
    output logic              read,
    output logic              busy
);

    localparam int READ_LEN = 2 * CLK_DIV;
    localparam int GAP_LEN  = 2 * GAP_CYCLES * CLK_DIV;
    localparam int MAX_LEN  = (GAP_LEN > READ_LEN) ? GAP_LEN : READ_LEN;
    localparam int WAIT_W   = $clog2(MAX_LEN);
    localparam int BIT_W    = $clog2(DATA_W + 1);
    localparam logic [WAIT_W-1:0] READ_LAST = WAIT_W'(READ_LEN - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);

    link_state_t       state, state_next;
    logic [DATA_W-1:0] hold_data, sr;
    logic              hold_valid;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_sr, shift_sr, accept;
    logic              rise_tick, fall_tick;

    assign ready      = !hold_valid;
    assign accept     = load && ready;
    assign S_data_out = sr[DATA_W-1];

    link_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .en       (state == SHIFT),
        .clr      (reset),
        .ic_clk   (ic_clk_ctrl),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_comb begin
        state_next = state;
        load_sr    = 1'b0;
        shift_sr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    load_sr    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // The last bit stays on the line through READ rather than shifting out.
                if (fall_tick) begin
                    if (bit_cnt == BIT_LAST) state_next = READ;
                    else                     shift_sr   = 1'b1;
                end
            end
            READ: begin
                if (wait_cnt == READ_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                    end else if (hold_valid) begin
                        load_sr    = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    if (hold_valid) begin
                        load_sr    = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            read       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            read  <= (state_next == READ);
            busy  <= (state_next != IDLE);

            if (load_sr) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= P_data_in;
            end

            if (load_sr) begin
                sr      <= hold_data;
                bit_cnt <= '0;
            end else begin
                if (shift_sr)  sr      <= {sr[DATA_W-2:0], 1'b0};
                if (rise_tick) bit_cnt <= bit_cnt + BIT_W'(1);
            end

            // READ and GAP share one phase timer, restarted on every state change.
            if (state_next != state)                 wait_cnt <= '0;
            else if (state == READ || state == GAP)  wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_p2s_link_tx.sv
// Bench for p2s_link_tx: two instances (CLK_DIV=2/GAP=1 and CLK_DIV=1/GAP=0) with a
// behavioural loopback receiver and a frame-timing model.
module tb_p2s_link_tx;

    logic       clk;
    logic       reset;
    logic [7:0] din0, din1;
    logic [1:0] ld, rdy, sd, ic, rd, bsy;
    int         cyc;
    int         total, bad;

    // Receiver model and frame observations, per instance
    logic [7:0] rx_shift[2];
    logic [7:0] frame[2];
    int         cur_rises[2], frame_rises[2], first_rise[2];
    int         read_start[2], read_len[2], busy_fall[2];
    int         frames_seen[2], toggles[2];
    logic [1:0] ic_prev, rd_prev, bsy_prev;
    logic [7:0] rx_q[$];
    int         rd_q[$];

    p2s_link_tx #(.DATA_W(8), .CLK_DIV(2), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .P_data_in(din0), .load(ld[0]), .ready(rdy[0]),
        .S_data_out(sd[0]), .ic_clk_ctrl(ic[0]), .read(rd[0]), .busy(bsy[0])
    );

    p2s_link_tx #(.DATA_W(8), .CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .P_data_in(din1), .load(ld[1]), .ready(rdy[1]),
        .S_data_out(sd[1]), .ic_clk_ctrl(ic[1]), .read(rd[1]), .busy(bsy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback receiver: samples data on each link-clock rise, captures the byte on read.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rx_shift[i]  = 8'h00;
                cur_rises[i] = 0;
            end else begin
                if (ic[i] === 1'b1 && ic_prev[i] === 1'b0) begin
                    rx_shift[i] = {rx_shift[i][6:0], sd[i]};
                    cur_rises[i]++;
                    if (cur_rises[i] == 1) first_rise[i] = cyc;
                end
                if (rd[i] === 1'b1 && rd_prev[i] === 1'b0) begin
                    frame[i]       = rx_shift[i];
                    frame_rises[i] = cur_rises[i];
                    cur_rises[i]   = 0;
                    read_start[i]  = cyc;
                    read_len[i]    = 0;
                    frames_seen[i]++;
                    if (i == 0) begin
                        rx_q.push_back(rx_shift[0]);
                        rd_q.push_back(cyc);
                    end
                end
                if (rd[i] === 1'b1) read_len[i]++;
                if (bsy[i] === 1'b0 && bsy_prev[i] === 1'b1) busy_fall[i] = cyc;
            end
            if (ic[i] === ~ic_prev[i]) toggles[i]++;
            ic_prev[i]  = ic[i];
            rd_prev[i]  = rd[i];
            bsy_prev[i] = bsy[i];
        end
    end

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds load until the byte is taken; returns the clk edge number of the accept.
    task automatic applyStimulus(input int inst, input logic [7:0] data, output int acc_cyc);
        int n;
        n = 0;
        if (inst == 0) din0 = data;
        else           din1 = data;
        ld[inst] = 1'b1;
        while (rdy[inst] !== 1'b1 && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput("accept_wait", {31'd0, rdy[inst]}, 32'd1);
        acc_cyc = cyc + 1;
        stepCycle();
        ld[inst] = 1'b0;
    endtask

    task automatic waitIdle(input int inst, input int nframes);
        int n;
        n = 0;
        while ((frames_seen[inst] < nframes || bsy[inst] !== 1'b0) && n < 3000) begin
            stepCycle();
            n++;
        end
        checkOutput("frame_count", frames_seen[inst], nframes);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_sdata"}, {31'd0, sd[0]},  32'd0);
        checkOutput({tag, "_icclk"}, {31'd0, ic[0]},  32'd0);
        checkOutput({tag, "_read"},  {31'd0, rd[0]},  32'd0);
        checkOutput({tag, "_busy"},  {31'd0, bsy[0]}, 32'd0);
        checkOutput({tag, "_ready"}, {31'd0, rdy[0]}, 32'd1);
    endtask

    initial begin
        int k, k1, k2, t0, nf, n, base, prev_start;
        int acc[12];
        int start_exp[12];
        logic [7:0] exp_b[12];

        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; ld = 2'b00; din0 = 8'h00; din1 = 8'h00;

        // Scenario 1: reset for 3 cycles, then quiet idle
        repeat (3) stepCycle();
        reset = 1'b0;
        stepCycle();
        checkIdleOutputs("rst");
        checkOutput("rst_ready1", {31'd0, rdy[1]}, 32'd1);
        t0 = toggles[0] + toggles[1];
        repeat (10) stepCycle();
        checkOutput("idle_toggles", toggles[0] + toggles[1], t0);

        // Scenario 2: single byte A5
        $display("[TB] single frame 0xA5");
        applyStimulus(0, 8'hA5, k);
        waitIdle(0, 1);
        checkOutput("a5_byte", {24'd0, frame[0]}, 32'hA5);
        checkOutput("a5_rises", frame_rises[0], 8);
        checkOutput("a5_first_rise", first_rise[0], k + 3);
        checkOutput("a5_read_start", read_start[0], k + 33);
        checkOutput("a5_read_len", read_len[0], 4);
        checkOutput("a5_busy_fall", busy_fall[0], k + 41);

        // Scenario 3: FF then 00 back-to-back, 3C offered while full
        $display("[TB] back-to-back 0xFF 0x00, 0x3C dropped");
        nf = frames_seen[0];
        applyStimulus(0, 8'hFF, k1);
        applyStimulus(0, 8'h00, k2);
        checkOutput("b2b_ready_low", {31'd0, rdy[0]}, 32'd0);
        din0 = 8'h3C;
        ld[0] = 1'b1;
        repeat (5) stepCycle();
        ld[0] = 1'b0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput("b2b_ready_rise", cyc, k1 + 41);
        waitIdle(0, nf + 2);
        repeat (60) stepCycle();
        checkOutput("b2b_no_extra", frames_seen[0], nf + 2);
        checkOutput("b2b_byte0", {24'd0, rx_q[nf]}, 32'hFF);
        checkOutput("b2b_byte1", {24'd0, rx_q[nf + 1]}, 32'h00);
        checkOutput("b2b_read0", rd_q[nf], k1 + 33);
        checkOutput("b2b_period", rd_q[nf + 1] - rd_q[nf], 40);

        // Scenario 4: reset mid-frame with a byte waiting in the holding register
        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'hC3, k);
        applyStimulus(0, 8'h5A, k2);
        n = 0;
        while (cur_rises[0] < 3 && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("c3_rise3", cur_rises[0], 3);
        checkOutput("c3_rise3_time", cyc, k + 11);
        reset = 1'b1;
        stepCycle();
        checkIdleOutputs("midrst");
        checkOutput("midrst_hold_valid", {31'd0, dut0.hold_valid}, 32'd0);
        reset = 1'b0;
        nf = frames_seen[0];
        repeat (3) stepCycle();
        applyStimulus(0, 8'h3C, k);
        waitIdle(0, nf + 1);
        checkOutput("after_rst_byte", {24'd0, frame[0]}, 32'h3C);
        checkOutput("after_rst_rises", frame_rises[0], 8);
        repeat (100) stepCycle();
        checkOutput("after_rst_no_extra", frames_seen[0], nf + 1);

        // Scenario 5: fastest settings on the second instance
        $display("[TB] CLK_DIV=1 GAP_CYCLES=0 frame 0x81");
        t0 = toggles[1];
        applyStimulus(1, 8'h81, k);
        waitIdle(1, 1);
        checkOutput("fast_byte", {24'd0, frame[1]}, 32'h81);
        checkOutput("fast_rises", frame_rises[1], 8);
        checkOutput("fast_first_rise", first_rise[1], k + 2);
        checkOutput("fast_toggles", toggles[1] - t0, 16);
        checkOutput("fast_read_start", read_start[1], k + 17);
        checkOutput("fast_read_len", read_len[1], 2);
        checkOutput("fast_busy_fall", busy_fall[1], k + 19);

        // Random traffic: each frame starts at the later of accept+1 and the previous start+40
        $display("[TB] random traffic");
        base = rx_q.size();
        prev_start = -1000;
        for (int j = 0; j < 12; j++) begin
            repeat ($urandom_range(0, 60)) stepCycle();
            exp_b[j] = 8'($urandom);
            applyStimulus(0, exp_b[j], acc[j]);
            start_exp[j] = (acc[j] + 1 > prev_start + 40) ? acc[j] + 1 : prev_start + 40;
            prev_start = start_exp[j];
        end
        waitIdle(0, frames_seen[0] < base + 12 ? base + 12 : frames_seen[0]);
        checkOutput("rnd_count", rx_q.size(), base + 12);
        for (int j = 0; j < 12; j++) begin
            if (base + j < rx_q.size()) begin
                checkOutput($sformatf("rnd_byte%0d", j), {24'd0, rx_q[base + j]}, {24'd0, exp_b[j]});
                checkOutput($sformatf("rnd_read%0d", j), rd_q[base + j], start_exp[j] + 32);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
